// File: rtl/butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly with valid/ready flow control.
// a_o = a + W*b, b_o = a - W*b; optional conj(W), /2 scaling, saturation.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   in_valid_i/in_ready_o   input handshake
//   inv_i, scale_i          per-beat conj(W) select and divide-by-2
//   twid_i, a_i, b_i        twiddle and operands, [0]=Re, [1]=Im
//   out_valid_o/out_ready_i output handshake
//   a_o, b_o                butterfly results
//   ovf_o, clr_ovf_i        sticky saturation flag and its clear
module butterfly_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 15,
    parameter int TWID_WIDTH = FRAC_BITS + 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       inv_i,
    input  logic                       scale_i,
    input  logic [1:0][TWID_WIDTH-1:0] twid_i,
    input  logic [1:0][DATA_WIDTH-1:0] a_i,
    input  logic [1:0][DATA_WIDTH-1:0] b_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [1:0][DATA_WIDTH-1:0] a_o,
    output logic [1:0][DATA_WIDTH-1:0] b_o,
    output logic                       ovf_o,
    input  logic                       clr_ovf_i
);

    localparam int DW = DATA_WIDTH;
    localparam int TW = TWID_WIDTH;
    localparam int PW = DW + TW;
    localparam int EW = DW + 2;

    localparam logic signed [PW:0]   RND  = (PW+1)'(1) <<< (FRAC_BITS - 1);
    localparam logic signed [EW-1:0] ONE  = EW'(1);
    localparam logic signed [EW-1:0] MAXV = EW'((1 <<< (DW - 1)) - 1);
    localparam logic signed [EW-1:0] MINV = EW'(-(1 <<< (DW - 1)));

    logic stall;
    logic adv;

    // Single global stall: the whole pipe freezes while the output is held.
    assign stall      = out_valid_o & ~out_ready_i;
    assign in_ready_o = ~stall;
    assign adv        = ~stall;

    // Stage 1 registers
    logic                 v1;
    logic                 sc1;
    logic signed [DW-1:0] a1_re, a1_im, b1_re, b1_im;
    logic signed [TW-1:0] w1_re, w1_im;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1 <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (adv) begin
            a1_re <= $signed(a_i[0]);
            a1_im <= $signed(a_i[1]);
            b1_re <= $signed(b_i[0]);
            b1_im <= $signed(b_i[1]);
            w1_re <= $signed(twid_i[0]);
            // Inverse transform uses conj(W): flip the imaginary sign here.
            w1_im <= inv_i ? -$signed(twid_i[1]) : $signed(twid_i[1]);
            sc1   <= scale_i;
        end
    end

    // Stage 2: complex rotation b*W, rounded back to data scale
    logic signed [PW:0]   p_re, p_im;
    logic signed [EW-1:0] r_re, r_im;

    assign p_re = b1_re * w1_re - b1_im * w1_im;
    assign p_im = b1_re * w1_im + b1_im * w1_re;
    assign r_re = EW'((p_re + RND) >>> FRAC_BITS);
    assign r_im = EW'((p_im + RND) >>> FRAC_BITS);

    logic                 v2;
    logic                 sc2;
    logic signed [DW-1:0] a2_re, a2_im;
    logic signed [EW-1:0] r2_re, r2_im;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v2 <= 1'b0;
        end else if (adv) begin
            v2 <= v1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (adv) begin
            a2_re <= a1_re;
            a2_im <= a1_im;
            r2_re <= r_re;
            r2_im <= r_im;
            sc2   <= sc1;
        end
    end

    // Stage 3: add/sub, optional halving, saturation. Result MSB = sat flag.
    function automatic logic [DW:0] fin(
        input logic signed [EW-1:0] x,
        input logic                 sc
    );
        logic signed [EW-1:0] y;
        y = sc ? (x + ONE) >>> 1 : x;
        if (y > MAXV) begin
            return {1'b1, DW'(MAXV)};
        end else if (y < MINV) begin
            return {1'b1, DW'(MINV)};
        end
        return {1'b0, DW'(y)};
    endfunction

    logic signed [EW-1:0] s_re, s_im, d_re, d_im;
    logic [DW:0]          fa_re, fa_im, fb_re, fb_im;
    logic                 sat;

    assign s_re  = EW'(a2_re) + r2_re;
    assign s_im  = EW'(a2_im) + r2_im;
    assign d_re  = EW'(a2_re) - r2_re;
    assign d_im  = EW'(a2_im) - r2_im;
    assign fa_re = fin(s_re, sc2);
    assign fa_im = fin(s_im, sc2);
    assign fb_re = fin(d_re, sc2);
    assign fb_im = fin(d_im, sc2);
    assign sat   = fa_re[DW] | fa_im[DW] | fb_re[DW] | fb_im[DW];

    // One-cycle pulse marking a saturating beat just loaded into the output.
    logic sat_p;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            a_o         <= '0;
            b_o         <= '0;
            sat_p       <= 1'b0;
        end else begin
            sat_p <= 1'b0;
            if (adv) begin
                out_valid_o <= v2;
                if (v2) begin
                    a_o[0] <= fa_re[DW-1:0];
                    a_o[1] <= fa_im[DW-1:0];
                    b_o[0] <= fb_re[DW-1:0];
                    b_o[1] <= fb_im[DW-1:0];
                    sat_p  <= sat;
                end
            end
        end
    end

    // Sticky flag; a new saturation wins over a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_o <= 1'b0;
        end else if (sat_p) begin
            ovf_o <= 1'b1;
        end else if (clr_ovf_i) begin
            ovf_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboard bench for butterfly_pipe: real-valued reference model,
// directed corner beats, stall/reset scenarios and a random stream.
module tb_butterfly_pipe;

    localparam int DW = 16;
    localparam int TW = 17;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid, in_ready;
    logic                inv, scale;
    logic [1:0][TW-1:0]  twid;
    logic [1:0][DW-1:0]  a, b, ao, bo;
    logic                out_valid, out_ready;
    logic                ovf, clr_ovf;

    always #5 clk = ~clk;

    butterfly_pipe dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .inv_i       (inv),
        .scale_i     (scale),
        .twid_i      (twid),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .a_o         (ao),
        .b_o         (bo),
        .ovf_o       (ovf),
        .clr_ovf_i   (clr_ovf)
    );

    typedef struct {
        real ar;
        real ai;
        real br;
        real bi;
    } exp_t;

    exp_t q[$];
    exp_t cur_exp;
    int   errors  = 0;
    int   checks  = 0;
    int   acc_cnt = 0;
    int   out_cnt = 0;
    bit   rnd_mode = 1'b0;
    bit   done;

    task automatic check(string name, longint got, longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic cmp(string name, logic [DW-1:0] got, real exp);
        real d;
        d = real'($signed(got)) - exp;
        checks++;
        if (d > 1.0 || d < -1.0) begin
            errors++;
            $display("FAIL %s: got %0d, expected %f", name,
                     $signed(got), exp);
        end
    endtask

    function automatic real clampr(real x);
        if (x > 32767.0) return 32767.0;
        if (x < -32768.0) return -32768.0;
        return x;
    endfunction

    // Ideal complex butterfly in real arithmetic.
    function automatic exp_t model(int ar, int ai, int br, int bi,
                                   int wr, int wi, bit iv, bit sc);
        exp_t e;
        real  wre, wim, pr, pi, k;
        wre  = wr / 32768.0;
        wim  = (iv ? -wi : wi) / 32768.0;
        pr   = br * wre - bi * wim;
        pi   = br * wim + bi * wre;
        k    = sc ? 0.5 : 1.0;
        e.ar = clampr((ar + pr) * k);
        e.ai = clampr((ai + pi) * k);
        e.br = clampr((ar - pr) * k);
        e.bi = clampr((ai - pi) * k);
        return e;
    endfunction

    function automatic int rnd_d();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic int rnd_w();
        return int'($urandom_range(0, 65536)) - 32768;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                out_cnt++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got beat, expected none");
                end else begin
                    e = q.pop_front();
                    cmp("a_re", ao[0], e.ar);
                    cmp("a_im", ao[1], e.ai);
                    cmp("b_re", bo[0], e.br);
                    cmp("b_im", bo[1], e.bi);
                end
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                q.push_back(cur_exp);
            end
        end
    end

    // Random backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at #1 after a posedge; returns #1 after the accepting edge.
    task automatic send(int ar, int ai, int br, int bi,
                        int wr, int wi, bit iv, bit sc);
        int n;
        n       = 0;
        a[0]    = ar[DW-1:0];
        a[1]    = ai[DW-1:0];
        b[0]    = br[DW-1:0];
        b[1]    = bi[DW-1:0];
        twid[0] = wr[TW-1:0];
        twid[1] = wi[TW-1:0];
        inv     = iv;
        scale   = sc;
        cur_exp = model(ar, ai, br, bi, wr, wi, iv, sc);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept, expected accept");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", q.size(), 0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("driver_done", done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0][DW-1:0] snap_a, snap_b;
        int a0, o0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_ovf   = 1'b0;
        inv       = 1'b0;
        scale     = 1'b0;
        a         = '0;
        b         = '0;
        twid      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_ovf", ovf, 0);
        check("rst_a_o", ao, 0);
        check("rst_b_o", bo, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Identity twiddle, latency check
        send(16384, 0, 8192, 0, 32768, 0, 0, 0);
        @(negedge clk);
        check("lat_c1", out_valid, 0);
        @(negedge clk);
        check("lat_c2", out_valid, 0);
        @(negedge clk);
        check("lat_c3", out_valid, 1);
        @(posedge clk);
        #1;
        drain();
        check("ovf_clean", ovf, 0);

        // W = -j, forward and inverse
        send(16384, 8192, 8192, -8192, 0, -32768, 0, 0);
        send(16384, 8192, 8192, -8192, 0, -32768, 1, 0);
        drain();

        // Saturation and sticky overflow
        send(24576, 0, 24576, 0, 32768, 0, 0, 0);
        drain();
        repeat (2) @(posedge clk);
        #1;
        check("ovf_set", ovf, 1);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_sticky", ovf, 1);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        check("ovf_clr", ovf, 0);
        send(24576, 0, 24576, 0, 32768, 0, 0, 1);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("ovf_scaled", ovf, 0);

        // Stall with 5 back-to-back beats
        out_ready = 1'b0;
        a0   = acc_cnt;
        o0   = out_cnt;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(rnd_d(), rnd_d(), rnd_d(), rnd_d(),
                         rnd_w(), rnd_w(), 1'($urandom), 1'($urandom));
                done = 1'b1;
            end
        join_none
        repeat (4) @(negedge clk);
        snap_a = ao;
        snap_b = bo;
        repeat (4) @(negedge clk);
        check("stall_inflight", acc_cnt - a0, 3);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_hold_a", ao, snap_a);
        check("stall_hold_b", bo, snap_b);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done();
        drain();
        check("stall_accepted", acc_cnt - a0, 5);
        check("stall_emitted", out_cnt - o0, 5);

        // Reset with 3 beats in flight
        out_ready = 1'b0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++)
                    send(rnd_d(), rnd_d(), rnd_d(), rnd_d(),
                         rnd_w(), rnd_w(), 1'b0, 1'b0);
                done = 1'b1;
            end
        join_none
        wait_done();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        o0 = out_cnt;
        repeat (10) @(negedge clk);
        check("mid_rst_no_stale", out_cnt - o0, 0);
        @(posedge clk);
        #1;

        // Random stream with random gaps and backpressure
        rnd_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(rnd_d(), rnd_d(), rnd_d(), rnd_d(),
                 rnd_w(), rnd_w(), 1'($urandom), 1'($urandom));
        end
        rnd_mode  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
